// File: rtl/switch_out_arbiter.sv
// Output-port arbiter of the 2x2 switch: merges two FWFT source queues into one registered stream.
// Optional build macro STARVE_GUARD_EN adds the low-priority starvation guard in PRIO mode.
module switch_out_arbiter #(
    parameter int         DATA_W       = 8,
    parameter logic [3:0] CFG_ADDR     = 4'h1,
    parameter int         STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_data_0,
    input  logic              fifo_empty_0,
    output logic              fifo_pop_0,
    input  logic [DATA_W-1:0] fifo_data_1,
    input  logic              fifo_empty_1,
    output logic              fifo_pop_1,
    input  logic [3:0]        configuration_address,
    input  logic [7:0]        configuration_data,
    input  logic              configuration_data_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              read_data_valid,
    output logic              source_add
);
    typedef enum logic [1:0] {M_STRICT, M_RR, M_PRIO} mode_e;
    typedef struct packed {
        logic vld;
        logic src;
    } grant_t;

    logic [7:0]             mode_reg;
    logic                   turn;
    logic                   last_src;
    logic [1:0]             empty;
    logic [1:0][DATA_W-1:0] data;
    logic                   hi;
    logic                   lo;
    logic                   starve_hit;
    mode_e                  mode;
    grant_t                 gnt;

    assign empty = {fifo_empty_1, fifo_empty_0};
    assign data  = {fifo_data_1, fifo_data_0};
    assign hi    = mode_reg[2];
    assign lo    = ~hi;

    // Upper mode bits are kept for software readback symmetry but never decoded.
    logic mode_unused;
    assign mode_unused = ^mode_reg[7:3];

    always_comb begin
        if (mode_reg[1])      mode = M_PRIO;
        else if (mode_reg[0]) mode = M_STRICT;
        else                  mode = M_RR;
    end

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counter only moves in PRIO; it saturates at the limit rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (mode == M_PRIO) begin
            if (empty[lo] || (gnt.vld && gnt.src == lo)) starve_cnt <= '0;
            else if (!starve_hit)                        starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        gnt = '0;
        case (mode)
            M_STRICT: begin
                // Idle on the other source's turn even if it has data.
                if (!empty[turn]) gnt = '{vld: 1'b1, src: turn};
            end
            M_RR: begin
                if (!empty[0] && !empty[1]) gnt = '{vld: 1'b1, src: ~last_src};
                else if (!empty[0])         gnt = '{vld: 1'b1, src: 1'b0};
                else if (!empty[1])         gnt = '{vld: 1'b1, src: 1'b1};
            end
            default: begin
                if (starve_hit && !empty[lo]) gnt = '{vld: 1'b1, src: lo};
                else if (!empty[hi])          gnt = '{vld: 1'b1, src: hi};
                else if (!empty[lo])          gnt = '{vld: 1'b1, src: lo};
            end
        endcase
    end

    assign fifo_pop_0 = rst & gnt.vld & ~gnt.src;
    assign fifo_pop_1 = rst & gnt.vld &  gnt.src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg        <= 8'b0000_0001;
            turn            <= 1'b0;
            last_src        <= 1'b1;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            source_add      <= 1'b0;
        end else begin
            if (configuration_data_valid && configuration_address == CFG_ADDR)
                mode_reg <= configuration_data;
            if (mode == M_STRICT)
                turn <= ~turn;
            if (gnt.vld) begin
                last_src   <= gnt.src;
                read_data  <= data[gnt.src];
                source_add <= gnt.src;
            end
            read_data_valid <= gnt.vld;
        end
    end
endmodule

// File: tb/tb_switch_out_arbiter.sv
// Scoreboard bench for switch_out_arbiter: queue models feed the DUT, expected words are checked in order.
module tb_switch_out_arbiter;
    localparam int         DATA_W       = 8;
    localparam logic [3:0] CFG_ADDR     = 4'h1;
    localparam int         STARVE_LIMIT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] fifo_data_0 = '0, fifo_data_1 = '0;
    logic              fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1;
    logic              fifo_pop_0, fifo_pop_1;
    logic [3:0]        configuration_address = '0;
    logic [7:0]        configuration_data = '0;
    logic              configuration_data_valid = 1'b0;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              source_add;

    always #5 clk = ~clk;

    switch_out_arbiter #(.DATA_W(DATA_W), .CFG_ADDR(CFG_ADDR), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .fifo_data_0(fifo_data_0), .fifo_empty_0(fifo_empty_0), .fifo_pop_0(fifo_pop_0),
        .fifo_data_1(fifo_data_1), .fifo_empty_1(fifo_empty_1), .fifo_pop_1(fifo_pop_1),
        .configuration_address(configuration_address), .configuration_data(configuration_data),
        .configuration_data_valid(configuration_data_valid),
        .read_data(read_data), .read_data_valid(read_data_valid), .source_add(source_add)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              s;
    } exp_t;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    exp_t              exp_q[$];
    int n_chk = 0, n_pass = 0;
    int cyc_idx, first_v, last_v, n_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_word(input logic [DATA_W-1:0] d, input logic s);
        exp_q.push_back('{d: d, s: s});
    endtask

    task automatic drive_inputs();
        fifo_empty_0 = (q0.size() == 0);
        fifo_empty_1 = (q1.size() == 0);
        fifo_data_0  = (q0.size() != 0) ? q0[0] : '0;
        fifo_data_1  = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic start_track();
        cyc_idx = 0; first_v = -1; last_v = -1; n_v = 0;
    endtask

    // One clock: sample at negedge, then retire popped heads just after posedge.
    task automatic cycle();
        logic p0, p1;
        exp_t e;
        @(negedge clk);
        p0 = fifo_pop_0;
        p1 = fifo_pop_1;
        chk("pop_exclusive", p0 & p1, 0);
        chk("pop0_on_empty", p0 & fifo_empty_0, 0);
        chk("pop1_on_empty", p1 & fifo_empty_1, 0);
        if (read_data_valid) begin
            if (first_v < 0) first_v = cyc_idx;
            last_v = cyc_idx;
            n_v++;
            if (exp_q.size() == 0) begin
                chk("extra_word", read_data_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", read_data, e.d);
                chk("source_add", source_add, e.s);
            end
        end
        cyc_idx++;
        @(posedge clk); #1;
        configuration_data_valid = 1'b0;
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        drive_inputs();
    endtask

    task automatic run(input string tag, input int exp_idle);
        int k = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && k < 200) begin
            cycle();
            k++;
        end
        chk({tag, "_drained_in_budget"}, (k < 200), 1);
        chk({tag, "_idle_cycles"}, (last_v - first_v + 1) - n_v, exp_idle);
        repeat (2) cycle();
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        configuration_address    = a;
        configuration_data       = d;
        configuration_data_valid = 1'b1;
        cycle();
    endtask

    task automatic build_prio(input int n);
        int  ih = 0, il = 0, cnt = 0;
        bit  guard;
`ifdef STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        // hi_src = 1: src1 is high priority, src0 is the starvation candidate
        while (ih < n || il < n) begin
            if (guard && cnt == STARVE_LIMIT && il < n) begin
                expect_word(DATA_W'(il), 1'b0); il++; cnt = 0;
            end else if (ih < n) begin
                expect_word(DATA_W'(8'h80 + ih), 1'b1); ih++;
                cnt = (il < n) ? ((cnt < STARVE_LIMIT) ? cnt + 1 : cnt) : 0;
            end else begin
                expect_word(DATA_W'(il), 1'b0); il++; cnt = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both queues already loaded: pops must stay low while rst is low.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(DATA_W'(8'hA0 + i));
            q1.push_back(DATA_W'(8'hB0 + i));
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", read_data_valid, 0);
        chk("rst_data", read_data, 0);
        chk("rst_src", source_add, 0);
        chk("rst_pop0", fifo_pop_0, 0);
        chk("rst_pop1", fifo_pop_1, 0);
        rst = 1'b1;

        // Default STRICT, both queues full
        for (int i = 0; i < 3; i++) begin
            expect_word(DATA_W'(8'hA0 + i), 1'b0);
            expect_word(DATA_W'(8'hB0 + i), 1'b1);
        end
        start_track();
        run("strict_both", 0);

        // STRICT, only src1 has data: one idle slot between its two words
        q1.push_back(8'h30); q1.push_back(8'h31);
        expect_word(8'h30, 1'b1); expect_word(8'h31, 1'b1);
        drive_inputs();
        start_track();
        run("strict_src1", 1);

        // RR, src1 word arrives mid-stream and is interleaved immediately
        cfg_write(CFG_ADDR, 8'h00);
        for (int i = 0; i < 4; i++) q0.push_back(DATA_W'(8'h50 + i));
        expect_word(8'h50, 1'b0); expect_word(8'h51, 1'b0); expect_word(8'h60, 1'b1);
        expect_word(8'h52, 1'b0); expect_word(8'h53, 1'b0);
        drive_inputs();
        start_track();
        cycle(); cycle();
        q1.push_back(8'h60);
        drive_inputs();
        run("rr", 0);

        // PRIO with hi_src=1, 20 words per source
        cfg_write(CFG_ADDR, 8'h06);
        for (int i = 0; i < 20; i++) begin
            q0.push_back(DATA_W'(i));
            q1.push_back(DATA_W'(8'h80 + i));
        end
        build_prio(20);
        drive_inputs();
        start_track();
        run("prio", 0);

        // Fresh reset, foreign-address write must not change STRICT, then reset mid-stream
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        configuration_address    = 4'h2;
        configuration_data       = 8'h02;
        configuration_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(DATA_W'(8'h40 + i));
            q1.push_back(DATA_W'(8'h70 + i));
            expect_word(DATA_W'(8'h40 + i), 1'b0);
            expect_word(DATA_W'(8'h70 + i), 1'b1);
        end
        drive_inputs();
        start_track();
        repeat (3) cycle();
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", read_data_valid, 0);
        chk("midrst_src", source_add, 0);
        chk("midrst_pop0", fifo_pop_0, 0);
        chk("midrst_pop1", fifo_pop_1, 0);
        exp_q.delete(); q0.delete(); q1.delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
